// File: rtl/probe_pkg.sv
// rtl/probe_pkg.sv - shared state encodings and timestamp width for the probe capture block
package probe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    localparam int TS_WIDTH = 16;

endpackage

// File: rtl/probe_capture_mem.sv
// rtl/probe_capture_mem.sv - sample buffer, one synchronous write port, one asynchronous read port
module probe_capture_mem #(
    parameter int width = 8,
    parameter int depth = 16,
    parameter int aw    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem [depth];

    // storage is deliberately not reset; the top gates the read data while invalid
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/probe_capture.sv
// rtl/probe_capture.sv - arm/trigger probe capture buffer with FWFT readout; PROBE_CAPTURE_TIMESTAMP_EN adds a 16-bit timestamp per sample
module probe_capture
    import probe_pkg::*;
#(
    parameter int size      = 1,
    parameter int log2depth = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [size-1:0]               IN,
    input  logic                          ARM,
    input  logic                          TRIG,
    input  logic                          ABORT,
    input  logic                          DEQ,
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
    output logic [size+TS_WIDTH-1:0]      DOUT,
`else
    output logic [size-1:0]               DOUT,
`endif
    output logic                          DOUT_VALID,
    output logic [1:0]                    STATE,
    output logic [log2depth:0]            COUNT
);

`ifdef PROBE_CAPTURE_TIMESTAMP_EN
    localparam int DW = size + TS_WIDTH;
`else
    localparam int DW = size;
`endif
    localparam int DEPTH = 1 << log2depth;
    localparam int PW    = (log2depth > 0) ? log2depth : 1;
    localparam int CW    = log2depth + 1;

    state_t        state, state_next;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          we, pop, clear;
    logic          last_write;
    logic [DW-1:0] wdata, rdata;

`ifdef PROBE_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;

    // free-running cycle counter, wraps naturally at 0xFFFF
    always_ff @(posedge CLK) begin
        if (RST) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    assign wdata = {ts, IN};
`else
    assign wdata = IN;
`endif

    // the write that brings occupancy up to depth ends the capture
    assign last_write = (count == CW'(DEPTH - 1));
    assign DOUT_VALID = (state == ST_READOUT) && (count != '0);
    assign DOUT       = DOUT_VALID ? rdata : '0;
    assign STATE      = state;
    assign COUNT      = count;

    // state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state and buffer controls; ABORT overrides everything else
    always_comb begin
        state_next = state;
        we         = 1'b0;
        pop        = 1'b0;
        clear      = 1'b0;
        if (ABORT) begin
            state_next = ST_IDLE;
            clear      = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ARM) begin
                        state_next = ST_ARMED;
                        clear      = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (TRIG) begin
                        we         = 1'b1;
                        state_next = last_write ? ST_READOUT : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    we = 1'b1;
                    if (last_write) begin
                        state_next = ST_READOUT;
                    end
                end
                ST_READOUT: begin
                    if (DEQ && DOUT_VALID) begin
                        pop = 1'b1;
                        if (count == CW'(1)) begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // pointers and occupancy; clearing discards unread samples by catching rptr up to wptr
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            rptr  <= wptr;
            count <= '0;
        end else begin
            if (we) begin
                wptr  <= (log2depth == 0) ? '0 : wptr + 1'b1;
                count <= count + 1'b1;
            end
            if (pop) begin
                rptr  <= (log2depth == 0) ? '0 : rptr + 1'b1;
                count <= count - 1'b1;
            end
        end
    end

    probe_capture_mem #(
        .width (DW),
        .depth (DEPTH),
        .aw    (PW)
    ) u_mem (
        .clk   (CLK),
        .we    (we),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (rdata)
    );

endmodule

// File: doc/probe_capture.md
PROBE_CAPTURE -- requirements
Module: probe_capture

Interface
REQ-001 Parameter: size, 1, bit width of captured probe value.
REQ-002 Parameter: log2depth, 4, log2 of buffer depth (depth = 2**log2depth, min 1).
REQ-003 Port: CLK  input  1  sole clock; all state on rising edge.
REQ-004 Port: RST  input  1  synchronous, active-high reset.
REQ-005 Port: IN  input  size  probe value to capture.
REQ-006 Port: ARM  input  1  arm request.
REQ-007 Port: TRIG  input  1  capture start.
REQ-008 Port: ABORT  input  1  return to IDLE, discard contents.
REQ-009 Port: DEQ  input  1  consume head sample.
REQ-010 Port: DOUT  output  size (size+TS_WIDTH with timestamp)  head sample.
REQ-011 Port: DOUT_VALID  output  1  head sample available.
REQ-012 Port: STATE  output  2  current state encoding.
REQ-013 Port: COUNT  output  log2depth+1  buffer occupancy.

Function
REQ-014 States SHALL be IDLE=0, ARMED=1, CAPTURE=2, READOUT=3.
REQ-015 IDLE: ARM SHALL move to ARMED next cycle with COUNT=0; TRIG, DEQ ignored.
REQ-016 ARMED: TRIG SHALL write IN of that same cycle as sample 0 and move to CAPTURE (COUNT=1); if depth=1, move directly to READOUT.
REQ-017 CAPTURE: IN SHALL be written every cycle; the cycle COUNT becomes depth SHALL move to READOUT; no sample is ever dropped or overwritten.
REQ-018 READOUT: DOUT_VALID SHALL equal (COUNT!=0); DOUT SHALL show oldest unread sample, first-word-fall-through, valid the first cycle in READOUT.
REQ-019 DEQ with DOUT_VALID=1 SHALL pop one sample per cycle; DEQ with DOUT_VALID=0 or outside READOUT SHALL be ignored.
REQ-020 Popping the last sample SHALL move to IDLE next cycle.
REQ-021 ABORT SHALL win over all other inputs in any state: next cycle STATE=IDLE, COUNT=0.
REQ-022 ARM outside IDLE and TRIG outside ARMED SHALL be ignored; simultaneous ARM+TRIG in IDLE SHALL arm only.
REQ-023 Write and read pointers SHALL be log2depth bits and wrap modulo depth; COUNT SHALL never exceed depth.
REQ-024 DOUT SHALL be don't-care while DOUT_VALID=0 but SHALL NOT contain X after reset in simulation (memory not reset; output gated to 0 when invalid).

Reset
REQ-025 RST=1 at a rising edge SHALL force STATE=IDLE, COUNT=0, DOUT_VALID=0, pointers=0, timestamp=0, DOUT=0, overriding all inputs including mid-capture/mid-readout.
REQ-026 Buffer memory contents SHALL NOT be reset.

Configuration
REQ-027 Macro PROBE_CAPTURE_TIMESTAMP_EN defined: a free-running TS_WIDTH=16 cycle counter (reset 0, wraps 0xFFFF->0x0000) SHALL be stored with each sample; DOUT = {timestamp, IN} with timestamp in upper bits.
REQ-028 Macro undefined: no counter; DOUT width = size; all other behaviour identical.

Structure
REQ-029 Shared package probe_pkg SHALL hold state encodings and TS_WIDTH.
REQ-030 Storage SHALL be sub-module probe_capture_mem: depth x width, one synchronous write port, one asynchronous read port.
REQ-031 Control FSM, pointers, occupancy and timestamp SHALL live in probe_capture.

Verification (size=8, log2depth=2, depth 4)
REQ-032 Reset mid-CAPTURE after 2 samples -> next cycle STATE=0, COUNT=0, DOUT_VALID=0.
REQ-033 ARM; TRIG with IN=0x11,0x22,0x33,0x44 on consecutive cycles -> STATE=3, COUNT=4, DOUT=0x11; four DEQ cycles -> 0x11,0x22,0x33,0x44 then STATE=0.
REQ-034 TRIG in IDLE, ARM in CAPTURE, DEQ in ARMED -> no state/COUNT change beyond normal capture progress.
REQ-035 ABORT on cycle of 3rd capture write, and separately with DEQ in READOUT -> STATE=0, COUNT=0 next cycle.
REQ-036 Two full capture/readout rounds back-to-back (pointer wrap) -> second round returns its own data in order.
REQ-037 With PROBE_CAPTURE_TIMESTAMP_EN, TRIG when counter=0xFFFE -> stored timestamps 0xFFFE,0xFFFF,0x0000,0x0001.
